// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared screen constants, car state encoding and LFSR taps
package graphics_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } car_state_t;

  // x^8+x^6+x^5+x^4+1 on a shift-left register: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Inclusive signed range test used by the sprite shape logic
  function automatic logic in_range(input logic signed [10:0] v,
                                    input logic signed [10:0] lo,
                                    input logic signed [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/npc_car_if.sv
// rtl/npc_car_if.sv - pixel, frame and game-control signals of one NPC car
interface npc_car_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_tick;
  logic        run;
  logic        hit;
  logic        on_car;
  logic        r_car;
  logic        g_car;
  logic        b_car;
  logic [10:0] car_y;
  logic        active;

  modport master (
    output pixel_x, pixel_y, frame_tick, run, hit,
    input  on_car, r_car, g_car, b_car, car_y, active
  );

  modport slave (
    input  pixel_x, pixel_y, frame_tick, run, hit,
    output on_car, r_car, g_car, b_car, car_y, active
  );
endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR with loadable seed
module lfsr8
  import graphics_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  // Advance every clock; a nonzero seed keeps the sequence off the all-zero lock-up state
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= seed;
    end else begin
      out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/npc_car.sv
// rtl/npc_car.sv - computer-driven car: spawn timer, per-frame motion and sprite pixels
module npc_car
  import graphics_pkg::*;
#(
  parameter int         CAR_W          = 32,
  parameter int         CAR_H          = 64,
  parameter int         SPEED          = 2,
  parameter int         ROAD_LEFT      = 160,
  parameter int         LANE_W         = 80,
  parameter logic [2:0] COLOR          = 3'b100,
  parameter logic [7:0] SEED           = 8'hA5,
  parameter int         RESPAWN_FRAMES = 30
) (
  input logic        clk,
  input logic        reset,
  npc_car_if.slave   bus
);

  localparam int                    CNT_W      = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);
  localparam logic [CNT_W-1:0]      CNT_RELOAD = CNT_W'(RESPAWN_FRAMES);
  localparam logic signed [10:0]    Y_INIT     = 11'(-CAR_H);
  localparam logic signed [10:0]    Y_STEP     = 11'(SPEED);
  localparam logic signed [10:0]    Y_LIMIT    = 11'(V_VISIBLE);
  localparam logic [9:0]            X_PAD      = 10'((LANE_W - CAR_W) / 2);

  car_state_t         state, state_n;
  logic signed [10:0] y_top, y_n, y_step;
  logic [1:0]         lane, lane_n;
  logic [CNT_W-1:0]   frame_cnt, cnt_n;
  logic [7:0]         lfsr;
  logic               unused_lfsr;

  logic [9:0]         x_left;
  logic signed [10:0] rel_x, rel_y;
  logic               in_box, edge_x, edge_y, window, on;
  logic [2:0]         rgb;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .out   (lfsr)
  );

  // Only the two low LFSR bits pick a lane
  assign unused_lfsr = ^lfsr[7:2];
  assign y_step      = y_top + Y_STEP;

  // State, position, lane and respawn counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      y_top     <= Y_INIT;
      lane      <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      y_top     <= y_n;
      lane      <= lane_n;
      frame_cnt <= cnt_n;
    end
  end

  // Next state: run=0 wins, then hit over frame_tick while driving
  always_comb begin
    state_n = state;
    y_n     = y_top;
    lane_n  = lane;
    cnt_n   = frame_cnt;
    if (!bus.run) begin
      state_n = IDLE;
      y_n     = Y_INIT;
      lane_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = WAIT;
          cnt_n   = CNT_RELOAD;
        end
        WAIT: begin
          if (bus.frame_tick) begin
            if (frame_cnt == '0) begin
              state_n = DRIVE;
              lane_n  = lfsr[1:0];
              y_n     = Y_INIT;
            end else begin
              cnt_n = frame_cnt - 1'b1;
            end
          end
        end
        DRIVE: begin
          if (bus.hit) begin
            state_n = WAIT;
            cnt_n   = CNT_RELOAD;
          end else if (bus.frame_tick) begin
            y_n = y_step;
            if (y_step >= Y_LIMIT) begin
              state_n = WAIT;
              cnt_n   = CNT_RELOAD;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Sprite shape for the current pixel: box minus 2x2 corners, window bands recoloured
  always_comb begin
    x_left = 10'(ROAD_LEFT) + 10'(lane) * 10'(LANE_W) + X_PAD;
    rel_x  = $signed({1'b0, bus.pixel_x}) - $signed({1'b0, x_left});
    rel_y  = $signed({bus.pixel_y[9], bus.pixel_y}) - y_top;
    in_box = (state == DRIVE)
          && in_range(rel_x, 11'(0), 11'(CAR_W - 1))
          && in_range(rel_y, 11'(0), 11'(CAR_H - 1));
    edge_x = in_range(rel_x, 11'(0), 11'(1)) || in_range(rel_x, 11'(CAR_W - 2), 11'(CAR_W - 1));
    edge_y = in_range(rel_y, 11'(0), 11'(1)) || in_range(rel_y, 11'(CAR_H - 2), 11'(CAR_H - 1));
    window = (in_range(rel_y, 11'(10), 11'(17)) || in_range(rel_y, 11'(CAR_H - 14), 11'(CAR_H - 9)))
          && in_range(rel_x, 11'(4), 11'(CAR_W - 5));
    on     = in_box && !(edge_x && edge_y);
    rgb    = 3'b000;
    if (on) begin
      rgb = window ? 3'b011 : COLOR;
    end
  end

  assign bus.on_car = on;
  assign bus.r_car  = rgb[2];
  assign bus.g_car  = rgb[1];
  assign bus.b_car  = rgb[0];
  assign bus.car_y  = y_top;
  assign bus.active = (state == DRIVE);

endmodule

// File: tb/tb_npc_car.sv
// tb/tb_npc_car.sv - directed table-driven bench for npc_car
module tb_npc_car;

  localparam int         CAR_W     = 32;
  localparam int         ROAD_LEFT = 160;
  localparam int         LANE_W    = 80;
  localparam logic [7:0] SEED      = 8'hA5;

  typedef struct {
    int         phase;
    int         dx;
    int         py;
    logic       on;
    logic [2:0] rgb;
  } pix_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [7:0] m_lfsr;
  logic [1:0] tick_lane;
  logic [1:0] exp_lane;
  int checks = 0;
  int errors = 0;
  pix_vec_t vecs[$];

  npc_car_if bus ();

  npc_car dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, new bit shifted in at the bottom
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    tick_lane = m_lfsr[1:0];
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_pix(input string name, input int dx, input int py, input logic on, input logic [2:0] rgb);
    int xl;
    xl = ROAD_LEFT + int'(exp_lane) * LANE_W + (LANE_W - CAR_W) / 2;
    bus.pixel_x = 10'(xl + dx);
    bus.pixel_y = 10'(py);
    @(negedge clk);
    chk({name, "_on"}, bus.on_car, on);
    chk({name, "_rgb"}, {bus.r_car, bus.g_car, bus.b_car}, rgb);
    step();
  endtask

  task automatic run_table(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph)
        check_pix($sformatf("pix_p%0d_%0d", ph, i), vecs[i].dx, vecs[i].py, vecs[i].on, vecs[i].rgb);
    end
  endtask

  task automatic add(input int ph, input int dx, input int py, input logic on, input logic [2:0] rgb);
    pix_vec_t v;
    v.phase = ph; v.dx = dx; v.py = py; v.on = on; v.rgb = rgb;
    vecs.push_back(v);
  endtask

  task automatic spawn_after_wait(input string name);
    ticks(30);
    chk({name, "_still_wait"}, bus.active, 1'b0);
    tick();
    exp_lane = tick_lane;
    chk({name, "_spawn_active"}, bus.active, 1'b1);
    chk({name, "_spawn_y"}, $signed(bus.car_y), -64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.pixel_x = '0; bus.pixel_y = '0;
    bus.frame_tick = 1'b0; bus.run = 1'b0; bus.hit = 1'b0;
    exp_lane = 2'd0;

    // phase 0: car_y = -62 (row 0 is rel_y 62, row 1 is rel_y 63)
    add(0, 24,  0, 1'b1, 3'b100);
    add(0, -1,  0, 1'b0, 3'b000);
    add(0, 32,  0, 1'b0, 3'b000);
    add(0,  0,  0, 1'b0, 3'b000);
    add(0, 31,  0, 1'b0, 3'b000);
    add(0,  2,  1, 1'b1, 3'b100);
    add(0,  1,  1, 1'b0, 3'b000);
    add(0, 29,  1, 1'b1, 3'b100);
    add(0, 31,  1, 1'b0, 3'b000);
    // phase 1: car_y = 100
    add(1,  4, 110, 1'b1, 3'b011);
    add(1,  3, 110, 1'b1, 3'b100);
    add(1, 27, 117, 1'b1, 3'b011);
    add(1, 28, 117, 1'b1, 3'b100);
    add(1,  4, 118, 1'b1, 3'b100);
    add(1,  4, 109, 1'b1, 3'b100);
    add(1, 10, 150, 1'b1, 3'b011);
    add(1, 10, 155, 1'b1, 3'b011);
    add(1, 10, 156, 1'b1, 3'b100);
    add(1, 10, 149, 1'b1, 3'b100);
    add(1,  0, 100, 1'b0, 3'b000);
    add(1,  2, 100, 1'b1, 3'b100);
    add(1,  0, 163, 1'b0, 3'b000);
    add(1,  2, 163, 1'b1, 3'b100);
    add(1, 31, 163, 1'b0, 3'b000);
    add(1, 29, 163, 1'b1, 3'b100);
    add(1,  5, 164, 1'b0, 3'b000);
    add(1,  5,  99, 1'b0, 3'b000);

    // reset state
    step(); step();
    reset = 1'b0;
    chk("reset_active", bus.active, 1'b0);
    chk("reset_car_y", $signed(bus.car_y), -64);
    check_pix("reset_pix", 24, 0, 1'b0, 3'b000);

    // 30 ticks of waiting after run goes high
    bus.run = 1'b1;
    step();
    for (int t = 0; t < 30; t++) begin
      tick();
      chk($sformatf("wait_tick%0d", t + 1), bus.active, 1'b0);
    end

    // align the spawn tick so the latched lane is 2
    guard = 0;
    while (m_lfsr[1:0] != 2'd2 && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      errors++;
      $display("FAIL lane_align: got timeout, expected lane 2 within 300 cycles");
    end
    tick();
    exp_lane = tick_lane;
    chk("spawn_active", bus.active, 1'b1);
    chk("spawn_car_y", $signed(bus.car_y), -64);
    tick();
    chk("first_move_y", $signed(bus.car_y), -62);
    run_table(0);

    // window bands at car_y = 100
    ticks(81);
    chk("window_y", $signed(bus.car_y), 100);
    run_table(1);

    // exit off the bottom after 272 ticks from spawn
    ticks(189);
    chk("pre_exit_y", $signed(bus.car_y), 478);
    chk("pre_exit_active", bus.active, 1'b1);
    check_pix("pre_exit_row479", 5, 479, 1'b1, 3'b100);
    tick();
    chk("exit_y", $signed(bus.car_y), 480);
    chk("exit_active", bus.active, 1'b0);
    check_pix("exit_row479", 5, 479, 1'b0, 3'b000);
    spawn_after_wait("respawn");
    tick();
    check_pix("respawn_lane", 24, 0, 1'b1, 3'b100);

    // hit together with frame_tick while driving
    bus.hit = 1'b1; bus.frame_tick = 1'b1;
    step();
    bus.hit = 1'b0; bus.frame_tick = 1'b0;
    step();
    chk("hit_active", bus.active, 1'b0);
    chk("hit_car_y", $signed(bus.car_y), -62);
    ticks(10);
    bus.hit = 1'b1;  // ignored while waiting
    step();
    bus.hit = 1'b0;
    step();
    ticks(20);
    chk("hit_wait_full", bus.active, 1'b0);
    tick();
    exp_lane = tick_lane;
    chk("hit_respawn_active", bus.active, 1'b1);
    chk("hit_respawn_y", $signed(bus.car_y), -64);
    ticks(3);
    check_pix("pre_drop_pix", 24, 0, 1'b1, 3'b100);

    // run dropped mid-drive
    bus.run = 1'b0;
    step();
    chk("drop_active", bus.active, 1'b0);
    chk("drop_car_y", $signed(bus.car_y), -64);
    check_pix("drop_pix", 24, 0, 1'b0, 3'b000);
    tick();
    chk("tick_while_idle", bus.active, 1'b0);
    bus.run = 1'b1;
    step();
    spawn_after_wait("rerun");
    tick();
    check_pix("rerun_lane", 24, 0, 1'b1, 3'b100);

    // synchronous reset mid-wait restores the seed as well
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    ticks(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_wait_active", bus.active, 1'b0);
    chk("rst_wait_car_y", $signed(bus.car_y), -64);
    step();
    spawn_after_wait("after_reset");
    tick();
    check_pix("after_reset_lane", 24, 0, 1'b1, 3'b100);
    check_pix("after_reset_left", -1, 0, 1'b0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
